hamm_err_sched: RTL

//  Sequences fault injection for the Hamming(7,4) self-test path. Drives the XOR error mask

---
 rtl/hamm_pkg.sv | 41 ++++
 rtl/hamm_err_sched_mask_gen.sv | 90 +++++++++
 rtl/hamm_err_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hamm_pkg.sv
// ============================================================================
//  Module   : hamm_pkg
//  Purpose  : Shared types and helpers for the Hamming(7,4) fault-injection
//             scheduler: codeword/syndrome widths, scheduler state encoding,
//             and the expected-syndrome function for an error mask.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hamm_pkg;

    localparam int CW_W     = 7;   // codeword width, bits numbered 1..7
    localparam int SYN_W    = 3;   // syndrome width
    localparam int N_SINGLE = 7;   // single-bit error patterns
    localparam int N_DOUBLE = 21;  // double-bit error patterns (7 choose 2)

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Syndrome a correct decoder reports for a given mask: the XOR of the
    // positions of all flipped bits (0 for a clean word).
    function automatic logic [SYN_W-1:0] exp_syn(input logic [1:CW_W] mask);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int k = 1; k <= CW_W; k++) begin
            if (mask[k]) begin
                s = s ^ SYN_W'(k);
            end
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hamm_err_sched_mask_gen.sv
// ============================================================================
//  Module   : hamm_mask_gen
//  Purpose  : Error-pattern sequencer. Produces the current error mask and a
//             flag marking the final pattern of a run.
//             Order: clean word, single bits 1..7, then (with
//             HAMM_DOUBLE_ERR_EN defined) every pair i<j in lexicographic
//             order. Without the macro the pair counters are not built.
//  Ports    : clk, rst   - clock, synchronous active-high reset
//             clear      - return to the first pattern
//             step       - advance to the next pattern
//             mask[1:7]  - current error mask
//             last       - current pattern is the final one of the run
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hamm_mask_gen
    import hamm_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            step,
    output logic [1:CW_W]   mask,
    output logic            last
);

    // Index 0 is the clean word, 1..7 select a single flipped bit.
    logic [2:0] r_idx;

`ifdef HAMM_DOUBLE_ERR_EN
    logic       r_pair;   // single patterns exhausted, walking the pairs
    logic [2:0] r_i;
    logic [2:0] r_j;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_idx  <= 3'd0;
            r_pair <= 1'b0;
            r_i    <= 3'd1;
            r_j    <= 3'd2;
        end else if (step) begin
            if (!r_pair) begin
                if (r_idx == 3'(N_SINGLE)) begin
                    r_pair <= 1'b1;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end else if (r_j == 3'd7) begin
                // row finished: next row starts just right of the new i
                r_i <= r_i + 3'd1;
                r_j <= r_i + 3'd2;
            end else begin
                r_j <= r_j + 3'd1;
            end
        end
    end

    always_comb begin
        mask = '0;
        last = r_pair && (r_i == 3'd6) && (r_j == 3'd7);
        for (int k = 1; k <= CW_W; k++) begin
            if (r_pair) begin
                mask[k] = (r_i == 3'(k)) || (r_j == 3'(k));
            end else begin
                mask[k] = (r_idx == 3'(k));
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_idx <= 3'd0;
        end else if (step) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    always_comb begin
        mask = '0;
        last = (r_idx == 3'(N_SINGLE));
        for (int k = 1; k <= CW_W; k++) begin
            mask[k] = (r_idx == 3'(k));
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/hamm_err_sched.sv
// ============================================================================
//  Module   : hamm_err_sched
//  Purpose  : Fault-injection scheduler for the Hamming(7,4) self-test path.
//             For each error pattern it drives the XOR mask to the injector,
//             waits (bounded by TIMEOUT) for the decoder syndrome, compares it
//             with the expected syndrome and tallies pass/fail.
//  Config   : HAMM_DOUBLE_ERR_EN - also run all 21 double-bit patterns
//  Params   : TIMEOUT - max WAIT cycles before a pattern counts as failed
//             CNT_W   - width of the saturating pass/fail counters
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start               - begin a run (ignored while busy)
//             signal[1:7]         - error mask to the injector
//             mask_valid          - mask stable, decoder may sample
//             dec_valid, dec_syn  - decoder result
//             busy, done          - run in progress / end-of-run pulse
//             pass_cnt, fail_cnt  - result tallies
//             last_fail[1:7]      - mask of the most recent failing pattern
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hamm_err_sched
    import hamm_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [1:CW_W]      signal,
    output logic               mask_valid,
    input  logic               dec_valid,
    input  logic [SYN_W-1:0]   dec_syn,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [1:CW_W]      last_fail
);

    localparam int TIMER_W = $clog2(TIMEOUT + 2);

    state_t               r_state;
    state_t               w_next;
    logic [TIMER_W-1:0]   r_timer;
    logic                 r_hit;        // syndrome matched on WAIT exit
    logic [1:CW_W]        w_mask;
    logic                 w_last;
    logic                 w_wait_exit;
    logic                 w_gen_clear;
    logic                 w_gen_step;

    // The generator restarts at the end of every run and again on an
    // accepted start, so an aborted or finished run never leaks its index.
    assign w_gen_clear = (r_state == DONE) || ((r_state == IDLE) && start);
    assign w_gen_step  = (r_state == NEXT);

    hamm_mask_gen u_mask_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (w_gen_clear),
        .step  (w_gen_step),
        .mask  (w_mask),
        .last  (w_last)
    );

    // A valid result on the expiry cycle still counts as a real answer.
    assign w_wait_exit = dec_valid || (r_timer == TIMER_W'(TIMEOUT));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = APPLY;
            APPLY:   w_next = WAIT;
            WAIT:    if (w_wait_exit) w_next = CHECK;
            CHECK:   w_next = NEXT;
            NEXT:    w_next = w_last ? DONE : APPLY;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_hit      <= 1'b0;
            signal     <= '0;
            mask_valid <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            last_fail  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        pass_cnt  <= '0;
                        fail_cnt  <= '0;
                        last_fail <= '0;
                    end
                end
                APPLY: begin
                    signal     <= w_mask;
                    mask_valid <= 1'b1;
                    r_timer    <= '0;
                end
                WAIT: begin
                    r_timer <= r_timer + TIMER_W'(1);
                    if (w_wait_exit) begin
                        r_hit <= dec_valid && (dec_syn == exp_syn(signal));
                    end
                end
                CHECK: begin
                    mask_valid <= 1'b0;
                    if (r_hit) begin
                        if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
                        last_fail <= signal;
                    end
                end
                NEXT: begin
                    if (w_last) signal <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule

`default_nettype wire
